qbus_mem_slave: RTL and testbench
=================================

Name: qbus_mem_slave

Overview:
- Q-bus responder (target) for the VM2 core's bus master: decodes SYNC address phase, services DATI/DATO/DATOB cycles from internal word RAM, returns RPLY.
- Sits on the shared ad/sync/din/dout/wtbt/rply bus next to the CPU; provides main RAM for the FPGA UKNC build.
- Waits for each data strobe to be released before ending the cycle; abandons cycles with no data strobe after a timeout.

Parameters:
- BASE_ADDR, 16'o000000, byte base of decoded window; low ADDR_BITS+1 bits ignored.
- ADDR_BITS, 12, word-address width; RAM = 2**ADDR_BITS words.
- WAIT_STATES, 0, extra clk cycles inserted before RPLY asserts (0..15).
- TIMEOUT, 15, clk cycles after address latch with no data strobe before returning to IDLE (1..255).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- init  in  1  bus INIT, active-high; synchronous return to IDLE, RAM contents kept.
- sync  in  1  address strobe, active-high; rising edge marks address phase.
- din  in  1  read data strobe, active-low.
- dout  in  1  write data strobe, active-low.
- wtbt  in  1  byte-write flag, active-high; sampled with the dout strobe.
- ad  inout  16  multiplexed address/data; driven only during read reply.
- rply  out  1  reply, active-low.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, rply=1, ad released (Z), addr latch=0, timeout counter=0.
- States: IDLE, ADDR, RD, WR, WAITR, REPLY, RELEASE.
- IDLE: sync_q tracks sync. On sync=1 & sync_q=0, latch ad[15:0] and compute hit = (ad[15:ADDR_BITS+1]==BASE_ADDR[15:ADDR_BITS+1]). hit -> ADDR; miss -> stay IDLE, no response.
- ADDR: counter increments each cycle.
  - din=0 & dout=1 -> RD.
  - dout=0 & din=1 -> WR; capture ad and wtbt this cycle.
  - din=0 & dout=0 (illegal) -> RELEASE without reply.
  - Counter reaches TIMEOUT -> IDLE.
  - New sync rising edge -> re-latch address and stay in ADDR.
- RD: RAM read at word index addr[ADDR_BITS:1]; synchronous RAM, 1-cycle latency.
- WR: RAM write in the same cycle.
  - wtbt=0: write the full word.
  - wtbt=1 & addr[0]=0: low byte lane only.
  - wtbt=1 & addr[0]=1: high byte from ad[15:8] only. Data-phase byte position follows PDP-11 convention.
- WAITR: hold WAIT_STATES cycles (skipped when 0) -> REPLY.
- Timing: strobe sampled active at cycle N -> rply=0 from cycle N+2+WAIT_STATES.
  - Read data is valid on ad in the same cycle rply first goes low.
  - ad is held until release.
- REPLY: rply=0; ad driven with read data only for a read cycle. Leave when the active strobe is sampled high -> RELEASE.
- RELEASE: rply=1, ad Z -> IDLE the next cycle. Data strobes stay ignored until both din and dout are high.
- init=1: synchronous, overrides all states -> IDLE, rply=1, ad Z. A write already committed to RAM stays committed.
- Reset mid-cycle: immediate release of rply and ad; no RAM write if reset is asserted before the WR clock edge.
- Address wrap: word index is truncated to ADDR_BITS; no wrap beyond the window, because out-of-window addresses are never hit.
- Never drives ad and asserts rply for a miss.

Optional Feature:
- Macro: QBUS_MEM_DBG_EN.
- Defined: adds outputs dbg_addr[15:0] (last latched address) and dbg_state[3:0] (current state encoding) for the 7-segment debug mux, plus dbg_cnt[15:0], a saturating count of completed cycles.
- Undefined: these ports and registers are absent; bus behaviour is identical either way.

Decomposition:
- Package qbus_pkg:
  - state encoding constants.
  - strobe polarity constants: SYNC_ACT=1, DIN_ACT=0, DOUT_ACT=0, RPLY_ACT=0.
  - cycle-type enum: DATI, DATO, DATOB.
  - Shared with the CPU bus FSM.
- Sub-module qbus_mem_ram: single-port synchronous RAM, 2**ADDR_BITS x 16, two byte-write enables, registered read.

Test Plan:
- DATO word: address 16'o001000, dout low 3 cycles with data 16'o123456, WAIT_STATES=0 -> rply low at N+2; follow with DATI from 16'o001000 -> ad=16'o123456 while rply low, ad Z after din release.
- DATOB: write 16'o177777 to 16'o001000, then wtbt=1 byte write to 16'o001001 with ad[15:8]=8'o000 -> DATI returns 16'o000377.
- Miss: BASE_ADDR=16'o000000, ADDR_BITS=12, address 16'o020000 -> rply stays 1, ad never driven through the whole din strobe.
- Timeout: sync pulse at 16'o000100, no strobe for 20 cycles with TIMEOUT=15 -> IDLE at cycle 15; a later din without sync gets no reply.
- WAIT_STATES=3 read -> rply low exactly at N+5; din held low 10 cycles -> rply held low throughout, high 1 cycle after din rises.
- Asynchronous reset: rst_n=0 while in REPLY on a read -> rply=1 and ad Z immediately, without waiting for a clock edge. Synchronous init: init=1 during WR -> no reply, state IDLE next cycle.

Source files
------------

// File: rtl/qbus_pkg.sv
// Q-bus shared definitions: state encoding, strobe polarities, cycle types.
// Used by the memory responder and the CPU-side bus FSM.
package qbus_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR    = 3'd1,
        S_RD      = 3'd2,
        S_WR      = 3'd3,
        S_WAITR   = 3'd4,
        S_REPLY   = 3'd5,
        S_RELEASE = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        DATI  = 2'd0,
        DATO  = 2'd1,
        DATOB = 2'd2
    } cyc_t;

    localparam logic SYNC_ACT = 1'b1;
    localparam logic DIN_ACT  = 1'b0;
    localparam logic DOUT_ACT = 1'b0;
    localparam logic RPLY_ACT = 1'b0;

    // Bits of a byte address that select the decoded window.
    function automatic logic [15:0] hi_mask(input int addr_bits);
        return 16'hffff << (addr_bits + 1);
    endfunction

endpackage

// File: rtl/qbus_mem_slave_if.sv
// Q-bus control strobes shared between the bus master and a responder.
// The multiplexed ad lines are a separate tristate net.
interface qbus_mem_slave_if;

    logic init;
    logic sync;
    logic din;
    logic dout;
    logic wtbt;
    logic rply;

    modport master (
        output init,
        output sync,
        output din,
        output dout,
        output wtbt,
        input  rply
    );

    modport slave (
        input  init,
        input  sync,
        input  din,
        input  dout,
        input  wtbt,
        output rply
    );

endinterface

// File: rtl/qbus_mem_ram.sv
// Single-port word RAM with per-byte write enables and registered read.
module qbus_mem_ram #(
    parameter int ADDR_BITS = 12
) (
    input  logic                 clk,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic                 re,
    input  logic                 we_lo,
    input  logic                 we_hi,
    input  logic [15:0]          wdata,
    output logic [15:0]          rdata
);

    logic [15:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we_lo) begin
            mem[addr][7:0] <= wdata[7:0];
        end
        if (we_hi) begin
            mem[addr][15:8] <= wdata[15:8];
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/qbus_mem_slave.sv
// Q-bus memory responder serving DATI/DATO/DATOB from internal word RAM.
// Define QBUS_MEM_DBG_EN to expose address/state/cycle-count debug outputs.
module qbus_mem_slave
    import qbus_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR   = 16'o000000,
    parameter int          ADDR_BITS   = 12,
    parameter int          WAIT_STATES = 0,
    parameter int          TIMEOUT     = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    qbus_mem_slave_if.slave        bus,
    inout  wire  [15:0]            ad
`ifdef QBUS_MEM_DBG_EN
    ,
    output logic [15:0]            dbg_addr,
    output logic [3:0]             dbg_state,
    output logic [15:0]            dbg_cnt
`endif
);

    localparam logic [15:0] HI_MASK = hi_mask(ADDR_BITS);
    localparam logic [7:0]  TO8     = 8'(TIMEOUT);
    localparam logic [3:0]  WS4     = 4'(WAIT_STATES);

    state_t      state;
    state_t      state_n;
    cyc_t        cyc_q;
    cyc_t        cyc_n;
    logic        sync_q;
    logic [15:0] addr_q;
    logic [15:0] addr_n;
    logic [7:0]  cnt;
    logic [7:0]  cnt_n;
    logic [3:0]  ws_cnt;
    logic [3:0]  ws_n;
    logic [15:0] wdata_q;
    logic        cap;
    logic        armed_q;
    logic        rply_q;
    logic        ad_oe_q;
    logic [15:0] rdata;

    logic sync_rise;
    logic din_act;
    logic dout_act;
    logic hit;
    logic strobe_rel;
    logic reply_on;
    logic ram_re;
    logic ram_we_lo;
    logic ram_we_hi;
    logic unused_addr;

    assign sync_rise  = (bus.sync == SYNC_ACT) && (sync_q != SYNC_ACT);
    assign din_act    = (bus.din == DIN_ACT);
    assign dout_act   = (bus.dout == DOUT_ACT);
    assign hit        = ((ad ^ BASE_ADDR) & HI_MASK) == 16'h0000;
    assign strobe_rel = (cyc_q == DATI) ? !din_act : !dout_act;
    assign reply_on   = (state == S_REPLY) && !strobe_rel && !bus.init;

    always_comb begin
        state_n = state;
        cyc_n   = cyc_q;
        addr_n  = addr_q;
        cnt_n   = cnt;
        ws_n    = ws_cnt;
        cap     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (sync_rise) begin
                    addr_n = ad;
                    cnt_n  = 8'd0;
                    if (hit) begin
                        state_n = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                cnt_n = cnt + 8'd1;
                if (sync_rise) begin
                    addr_n = ad;
                    cnt_n  = 8'd0;
                    if (!hit) begin
                        state_n = S_IDLE;
                    end
                end else if (armed_q && din_act && dout_act) begin
                    state_n = S_RELEASE;
                end else if (armed_q && din_act) begin
                    state_n = S_RD;
                    cyc_n   = DATI;
                end else if (armed_q && dout_act) begin
                    state_n = S_WR;
                    cyc_n   = bus.wtbt ? DATOB : DATO;
                    cap     = 1'b1;
                end else if (cnt_n == TO8) begin
                    state_n = S_IDLE;
                end
            end
            S_RD, S_WR: begin
                ws_n    = WS4;
                state_n = (WS4 == 4'd0) ? S_REPLY : S_WAITR;
            end
            S_WAITR: begin
                ws_n = ws_cnt - 4'd1;
                if (ws_cnt <= 4'd1) begin
                    state_n = S_REPLY;
                end
            end
            S_REPLY: begin
                if (strobe_rel) begin
                    state_n = S_RELEASE;
                end
            end
            S_RELEASE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        if (bus.init) begin
            state_n = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cyc_q   <= DATI;
            sync_q  <= ~SYNC_ACT;
            addr_q  <= 16'h0000;
            cnt     <= 8'd0;
            ws_cnt  <= 4'd0;
            wdata_q <= 16'h0000;
            armed_q <= 1'b0;
            rply_q  <= ~RPLY_ACT;
            ad_oe_q <= 1'b0;
        end else begin
            state  <= state_n;
            cyc_q  <= cyc_n;
            sync_q <= bus.sync;
            addr_q <= addr_n;
            cnt    <= cnt_n;
            ws_cnt <= ws_n;
            if (cap) begin
                wdata_q <= ad;
            end
            // Strobes re-arm only after both have been seen released.
            if (!din_act && !dout_act) begin
                armed_q <= 1'b1;
            end else if (state_n == S_RELEASE) begin
                armed_q <= 1'b0;
            end
            rply_q  <= reply_on ? RPLY_ACT : ~RPLY_ACT;
            ad_oe_q <= reply_on && (cyc_q == DATI);
        end
    end

    assign ram_re    = (state == S_RD) && !bus.init;
    assign ram_we_lo = (state == S_WR) && !bus.init
                     && ((cyc_q == DATO) || !addr_q[0]);
    assign ram_we_hi = (state == S_WR) && !bus.init
                     && ((cyc_q == DATO) || addr_q[0]);

    qbus_mem_ram #(
        .ADDR_BITS(ADDR_BITS)
    ) u_ram (
        .clk   (clk),
        .addr  (addr_q[ADDR_BITS:1]),
        .re    (ram_re),
        .we_lo (ram_we_lo),
        .we_hi (ram_we_hi),
        .wdata (wdata_q),
        .rdata (rdata)
    );

    assign ad          = ad_oe_q ? rdata : 16'hzzzz;
    assign bus.rply    = rply_q;
    assign unused_addr = ^addr_q;

`ifdef QBUS_MEM_DBG_EN
    assign dbg_addr  = addr_q;
    assign dbg_state = {1'b0, state};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_cnt <= 16'h0000;
        end else if (state == S_REPLY && state_n == S_RELEASE
                     && dbg_cnt != 16'hffff) begin
            dbg_cnt <= dbg_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_qbus_mem_slave.sv
// Directed bench for qbus_mem_slave: two responders on one shared Q-bus.
// dut0 at 000000 with no wait states, dut1 at 040000 with 3 wait states.
module tb_qbus_mem_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init = 1'b0;
    logic        sync = 1'b0;
    logic        din = 1'b1;
    logic        dout = 1'b1;
    logic        wtbt = 1'b0;
    logic [15:0] ad_drv = 16'h0000;
    logic        ad_oe = 1'b0;
    wire  [15:0] ad;
    wire         rply;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign ad = ad_oe ? ad_drv : 16'hzzzz;

    for (genvar i = 0; i < 16; i++) begin : g_pu
        pullup (ad[i]);
    end

    qbus_mem_slave_if bus0 ();
    qbus_mem_slave_if bus1 ();

    assign bus0.init = init;
    assign bus0.sync = sync;
    assign bus0.din  = din;
    assign bus0.dout = dout;
    assign bus0.wtbt = wtbt;
    assign bus1.init = init;
    assign bus1.sync = sync;
    assign bus1.din  = din;
    assign bus1.dout = dout;
    assign bus1.wtbt = wtbt;
    assign rply = bus0.rply & bus1.rply;

`ifdef QBUS_MEM_DBG_EN
    logic [15:0] dbg_addr0, dbg_addr1, dbg_cnt0, dbg_cnt1;
    logic [3:0]  dbg_state0, dbg_state1;
`endif

    qbus_mem_slave #(
        .BASE_ADDR(16'o000000), .ADDR_BITS(12),
        .WAIT_STATES(0), .TIMEOUT(15)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .ad(ad)
`ifdef QBUS_MEM_DBG_EN
        , .dbg_addr(dbg_addr0), .dbg_state(dbg_state0), .dbg_cnt(dbg_cnt0)
`endif
    );

    qbus_mem_slave #(
        .BASE_ADDR(16'o040000), .ADDR_BITS(12),
        .WAIT_STATES(3), .TIMEOUT(15)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .ad(ad)
`ifdef QBUS_MEM_DBG_EN
        , .dbg_addr(dbg_addr1), .dbg_state(dbg_state1), .dbg_cnt(dbg_cnt1)
`endif
    );

    // kind: 0 = DATI, 1 = DATO/DATOB, 2 = both strobes (illegal).
    // lat counts edges from the strobe-sampling edge to first rply low.
    task automatic run_cycle(
        input  logic [15:0] a,
        input  int          kind,
        input  logic        bw,
        input  logic [15:0] wd,
        input  int          pre,
        input  int          hold,
        output int          lat,
        output logic [15:0] data,
        output int          low_cnt,
        output int          drv_cnt,
        output logic        rel_rply,
        output logic [15:0] rel_ad
    );
        lat = -1;
        data = 16'h0000;
        low_cnt = 0;
        drv_cnt = 0;
        @(posedge clk); #1;
        ad_drv = a;
        ad_oe = 1'b1;
        sync = 1'b1;
        repeat (pre + 1) begin
            @(posedge clk); #1;
        end
        case (kind)
            0: begin ad_oe = 1'b0; din = 1'b0; end
            1: begin ad_drv = wd; wtbt = bw; dout = 1'b0; end
            default: begin ad_oe = 1'b0; din = 1'b0; dout = 1'b0; end
        endcase
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (rply == 1'b0) begin
                if (lat < 0) begin
                    lat = k;
                    data = ad;
                end
                low_cnt++;
            end
            if (kind != 1 && ad !== 16'hffff) drv_cnt++;
        end
        din = 1'b1;
        dout = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rel_rply = rply;
        rel_ad = ad;
        sync = 1'b0;
        wtbt = 1'b0;
        ad_oe = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    int          lat, lc, dc;
    logic [15:0] d, ra;
    logic        rr;

    task automatic test_reset();
        #12;
        n_checks++;
        if (rply !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_rply: got %b want 1", rply);
        end
        n_checks++;
        if (ad !== 16'hffff) begin
            n_fail++;
            $display("FAIL reset_ad: got %h want released", ad);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_dato_dati();
        run_cycle(16'o001000, 1, 1'b0, 16'o123456, 0, 3,
                  lat, d, lc, dc, rr, ra);
        n_checks++;
        if (lat !== 2) begin
            n_fail++;
            $display("FAIL dato_lat: got %0d want 2", lat);
        end
        n_checks++;
        if (lc !== 1 || rr !== 1'b1) begin
            n_fail++;
            $display("FAIL dato_rply: low %0d rel %b want 1 1", lc, rr);
        end
        run_cycle(16'o001000, 0, 1'b0, 16'h0, 0, 3,
                  lat, d, lc, dc, rr, ra);
        n_checks++;
        if (lat !== 2 || d !== 16'o123456) begin
            n_fail++;
            $display("FAIL dati_data: lat %0d data %o want 2 123456", lat, d);
        end
        n_checks++;
        if (rr !== 1'b1 || ra !== 16'hffff) begin
            n_fail++;
            $display("FAIL dati_release: rply %b ad %h want 1 ffff", rr, ra);
        end
    endtask

    task automatic test_datob();
        run_cycle(16'o001000, 1, 1'b0, 16'o177777, 0, 3,
                  lat, d, lc, dc, rr, ra);
        run_cycle(16'o001001, 1, 1'b1, 16'h00ab, 0, 3,
                  lat, d, lc, dc, rr, ra);
        n_checks++;
        if (lat !== 2) begin
            n_fail++;
            $display("FAIL datob_lat: got %0d want 2", lat);
        end
        run_cycle(16'o001000, 0, 1'b0, 16'h0, 0, 3,
                  lat, d, lc, dc, rr, ra);
        n_checks++;
        if (d !== 16'o000377) begin
            n_fail++;
            $display("FAIL datob_hi: got %o want 000377", d);
        end
        run_cycle(16'o001000, 1, 1'b1, 16'h5a34, 0, 3,
                  lat, d, lc, dc, rr, ra);
        run_cycle(16'o001000, 0, 1'b0, 16'h0, 0, 3,
                  lat, d, lc, dc, rr, ra);
        n_checks++;
        if (d !== 16'h0034) begin
            n_fail++;
            $display("FAIL datob_lo: got %h want 0034", d);
        end
    endtask

    task automatic test_miss();
        run_cycle(16'o000000, 1, 1'b0, 16'o052525, 0, 3,
                  lat, d, lc, dc, rr, ra);
        run_cycle(16'o020000, 0, 1'b0, 16'h0, 0, 5,
                  lat, d, lc, dc, rr, ra);
        n_checks++;
        if (lat !== -1 || lc !== 0) begin
            n_fail++;
            $display("FAIL miss_rply: lat %0d low %0d want -1 0", lat, lc);
        end
        n_checks++;
        if (dc !== 0) begin
            n_fail++;
            $display("FAIL miss_ad: driven %0d samples want 0", dc);
        end
    endtask

    task automatic test_timeout();
        run_cycle(16'o000100, 0, 1'b0, 16'h0, 20, 5,
                  lat, d, lc, dc, rr, ra);
        n_checks++;
        if (lat !== -1 || lc !== 0) begin
            n_fail++;
            $display("FAIL timeout_rply: lat %0d low %0d want -1 0", lat, lc);
        end
        n_checks++;
        if (dc !== 0) begin
            n_fail++;
            $display("FAIL timeout_ad: driven %0d samples want 0", dc);
        end
        run_cycle(16'o000100, 0, 1'b0, 16'h0, 13, 4,
                  lat, d, lc, dc, rr, ra);
        n_checks++;
        if (lat !== 2) begin
            n_fail++;
            $display("FAIL timeout_early: lat %0d want 2", lat);
        end
    endtask

    task automatic test_wait_states();
        run_cycle(16'o040000, 1, 1'b0, 16'o054321, 0, 7,
                  lat, d, lc, dc, rr, ra);
        n_checks++;
        if (lat !== 5) begin
            n_fail++;
            $display("FAIL ws_write_lat: got %0d want 5", lat);
        end
        run_cycle(16'o040000, 0, 1'b0, 16'h0, 0, 10,
                  lat, d, lc, dc, rr, ra);
        n_checks++;
        if (lat !== 5 || d !== 16'o054321) begin
            n_fail++;
            $display("FAIL ws_read: lat %0d data %o want 5 054321", lat, d);
        end
        n_checks++;
        if (lc !== 5) begin
            n_fail++;
            $display("FAIL ws_hold: low %0d want 5", lc);
        end
        n_checks++;
        if (rr !== 1'b1 || ra !== 16'hffff) begin
            n_fail++;
            $display("FAIL ws_release: rply %b ad %h want 1 ffff", rr, ra);
        end
    endtask

    task automatic test_illegal();
        run_cycle(16'o001000, 2, 1'b0, 16'h0, 0, 4,
                  lat, d, lc, dc, rr, ra);
        n_checks++;
        if (lat !== -1 || dc !== 0) begin
            n_fail++;
            $display("FAIL illegal: lat %0d driven %0d want -1 0", lat, dc);
        end
        run_cycle(16'o001000, 0, 1'b0, 16'h0, 0, 3,
                  lat, d, lc, dc, rr, ra);
        n_checks++;
        if (lat !== 2 || d !== 16'h0034) begin
            n_fail++;
            $display("FAIL illegal_after: lat %0d data %h want 2 0034", lat, d);
        end
    endtask

    task automatic test_init();
        int low;
        low = 0;
        @(posedge clk); #1;
        ad_drv = 16'o001002;
        ad_oe = 1'b1;
        sync = 1'b1;
        @(posedge clk); #1;
        ad_drv = 16'o070707;
        dout = 1'b0;
        @(posedge clk); #1;
        init = 1'b1;
        @(posedge clk); #1;
        init = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (rply == 1'b0) low++;
        end
        dout = 1'b1;
        sync = 1'b0;
        ad_oe = 1'b0;
        repeat (2) @(posedge clk);
        n_checks++;
        if (low !== 0) begin
            n_fail++;
            $display("FAIL init_noreply: low %0d want 0", low);
        end
        run_cycle(16'o001000, 0, 1'b0, 16'h0, 0, 3,
                  lat, d, lc, dc, rr, ra);
        n_checks++;
        if (lat !== 2 || d !== 16'h0034) begin
            n_fail++;
            $display("FAIL init_recover: lat %0d data %h want 2 0034", lat, d);
        end
    endtask

    task automatic test_async_reset();
        bit seen;
        seen = 1'b0;
        run_cycle(16'o001004, 1, 1'b0, 16'o012345, 0, 3,
                  lat, d, lc, dc, rr, ra);
        @(posedge clk); #1;
        ad_drv = 16'o001004;
        ad_oe = 1'b1;
        sync = 1'b1;
        @(posedge clk); #1;
        ad_oe = 1'b0;
        din = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (rply == 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL areset_reply: rply never low within 10 cycles");
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (rply !== 1'b1 || ad !== 16'hffff) begin
            n_fail++;
            $display("FAIL areset_now: rply %b ad %h want 1 ffff", rply, ad);
        end
        din = 1'b1;
        sync = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        run_cycle(16'o001004, 0, 1'b0, 16'h0, 0, 3,
                  lat, d, lc, dc, rr, ra);
        n_checks++;
        if (lat !== 2 || d !== 16'o012345) begin
            n_fail++;
            $display("FAIL areset_ram: lat %0d data %o want 2 012345", lat, d);
        end
    endtask

    initial begin
        test_reset();
        test_dato_dati();
        test_datob();
        test_miss();
        test_timeout();
        test_wait_states();
        test_illegal();
        test_init();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
